// File: rtl/mtimer_if.sv
// Wishbone slave bus bundle for the machine timer; signal suffixes are from the timer's point of view.
interface mtimer_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [2:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with prescaler, Wishbone-mapped; irq_o registered from the compare.
// Every request acked one edge later for one cycle (back-to-back requests every other cycle); no stall beyond that.
module mtimer #(
  parameter int PRESCALE_W = 8  // DIV lives in CTRL[8 +: PRESCALE_W], so at most 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mtimer_if.slave     wb,
  output logic [63:0] mtime_o,
  output logic        irq_o
);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_CTRL     = 3'd4;
  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_irq;

  logic                  w_req;
  logic                  w_wr;
  logic                  w_ctrl_wr;
  logic                  w_tick;
  logic [31:0]           w_ctrl;
  logic [31:0]           w_rdata;
  logic [63:0]           w_mtime_nxt;
  logic [63:0]           w_mtimecmp_nxt;
  logic                  w_en_nxt;
  logic [PRESCALE_W-1:0] w_div_nxt;
  logic [PRESCALE_W-1:0] w_cnt_nxt;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // The held ack masks the request so each transfer is seen exactly once.
  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb.wb_we_i;
  assign w_ctrl_wr = w_wr & (wb.wb_adr_i == ADR_CTRL);
  assign w_tick    = r_en & (r_cnt == r_div);

  always_comb begin
    w_ctrl                   = '0;
    w_ctrl[0]                = r_en;
    w_ctrl[8 +: PRESCALE_W]  = r_div;
  end

  always_comb begin
    w_rdata = '0;
    case (wb.wb_adr_i)
      ADR_MTIME_LO: w_rdata = r_mtime[31:0];
      ADR_MTIME_HI: w_rdata = r_mtime[63:32];
      ADR_CMP_LO:   w_rdata = r_mtimecmp[31:0];
      ADR_CMP_HI:   w_rdata = r_mtimecmp[63:32];
      ADR_CTRL:     w_rdata = w_ctrl;
      default:      w_rdata = '0;
    endcase
  end

  // A bus write to mtime replaces the tick's increment rather than adding to it.
  always_comb begin
    w_mtime_nxt    = w_tick ? r_mtime + 64'd1 : r_mtime;
    w_mtimecmp_nxt = r_mtimecmp;
    w_en_nxt       = r_en;
    w_div_nxt      = r_div;
    if (w_wr) begin
      case (wb.wb_adr_i)
        ADR_MTIME_LO: w_mtime_nxt = {r_mtime[63:32],
                                     f_merge(r_mtime[31:0], wb.wb_dat_i, wb.wb_sel_i)};
        ADR_MTIME_HI: w_mtime_nxt = {f_merge(r_mtime[63:32], wb.wb_dat_i, wb.wb_sel_i),
                                     r_mtime[31:0]};
        ADR_CMP_LO:   w_mtimecmp_nxt = {r_mtimecmp[63:32],
                                        f_merge(r_mtimecmp[31:0], wb.wb_dat_i, wb.wb_sel_i)};
        ADR_CMP_HI:   w_mtimecmp_nxt = {f_merge(r_mtimecmp[63:32], wb.wb_dat_i, wb.wb_sel_i),
                                        r_mtimecmp[31:0]};
        ADR_CTRL: begin
          if (wb.wb_sel_i[0]) w_en_nxt = wb.wb_dat_i[0];
          for (int i = 0; i < PRESCALE_W; i++) begin
            if (wb.wb_sel_i[1 + i/8]) w_div_nxt[i] = wb.wb_dat_i[8 + i];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_ONE;
    if (w_ctrl_wr || !r_en || w_tick) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_en       <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_en       <= w_en_nxt;
      r_div      <= w_div_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ack      <= w_req;
      r_dat      <= w_req ? w_rdata : 32'd0;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign mtime_o     = r_mtime;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: register-map vector table plus timed sequences for prescaler, wrap, irq, tick/write race and reset.
module tb_mtimer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] mtime_o;
  logic        irq_o;

  mtimer_if bus ();

  mtimer #(.PRESCALE_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wb      (bus.slave),
    .mtime_o (mtime_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NVEC = 28;
  vec_t tbl [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Called 1 time unit after an edge; returns 1 time unit after the edge that drops ack.
  task automatic xfer(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd,
                      output logic irq_at_ack, output logic [63:0] mt_at_ack);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    step(1);
    check("ack_rise", {63'd0, bus.wb_ack_o}, 64'd1);
    rd         = bus.wb_dat_o;
    irq_at_ack = irq_o;
    mt_at_ack  = mtime_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    step(1);
    check("ack_fall", {63'd0, bus.wb_ack_o}, 64'd0);
    check("dat_clear", {32'd0, bus.wb_dat_o}, 64'd0);
  endtask

  task automatic bus_wr(input logic [2:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    logic        ia;
    logic [63:0] ma;
    xfer(1'b1, adr, dat, 4'hF, rd, ia, ma);
  endtask

  task automatic bus_rd(input logic [2:0] adr, output logic [31:0] d);
    logic        ia;
    logic [63:0] ma;
    xfer(1'b0, adr, 32'd0, 4'hF, d, ia, ma);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ia;
    logic [63:0] ma;
    logic [63:0] old_mt;
    logic [63:0] exp_mt;
    logic        found;

    tbl[0]  = '{1'b0, 3'd0, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[1]  = '{1'b0, 3'd1, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[2]  = '{1'b0, 3'd2, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 3'd3, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, 3'd4, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[5]  = '{1'b0, 3'd5, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[6]  = '{1'b0, 3'd6, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[7]  = '{1'b0, 3'd7, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[8]  = '{1'b1, 3'd2, 32'h1234_5678, 4'hF, 32'hFFFF_FFFF};
    tbl[9]  = '{1'b0, 3'd2, 32'h0000_0000, 4'hF, 32'h1234_5678};
    tbl[10] = '{1'b1, 3'd2, 32'h0000_AB00, 4'h2, 32'h1234_5678};
    tbl[11] = '{1'b0, 3'd2, 32'h0000_0000, 4'hF, 32'h1234_AB78};
    tbl[12] = '{1'b1, 3'd5, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
    tbl[13] = '{1'b0, 3'd5, 32'h0000_0000, 4'hF, 32'h0000_0000};
    tbl[14] = '{1'b1, 3'd4, 32'hFFFF_FF00, 4'hF, 32'h0000_0000};
    tbl[15] = '{1'b0, 3'd4, 32'h0000_0000, 4'hF, 32'h0000_FF00};
    tbl[16] = '{1'b1, 3'd4, 32'h0000_0000, 4'h1, 32'h0000_FF00};
    tbl[17] = '{1'b0, 3'd4, 32'h0000_0000, 4'hF, 32'h0000_FF00};
    tbl[18] = '{1'b1, 3'd4, 32'h0000_0000, 4'hF, 32'h0000_FF00};
    tbl[19] = '{1'b1, 3'd1, 32'hCAFE_BABE, 4'hC, 32'h0000_0000};
    tbl[20] = '{1'b0, 3'd1, 32'h0000_0000, 4'hF, 32'hCAFE_0000};
    tbl[21] = '{1'b1, 3'd0, 32'h1122_3344, 4'h1, 32'h0000_0000};
    tbl[22] = '{1'b0, 3'd0, 32'h0000_0000, 4'hF, 32'h0000_0044};
    tbl[23] = '{1'b1, 3'd1, 32'h0000_0000, 4'hF, 32'hCAFE_0000};
    tbl[24] = '{1'b1, 3'd0, 32'h0000_0000, 4'hF, 32'h0000_0044};
    tbl[25] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h1234_AB78};
    tbl[26] = '{1'b0, 3'd2, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF};
    tbl[27] = '{1'b0, 3'd0, 32'h0000_0000, 4'hF, 32'h0000_0000};

    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 3'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_sel_i = 4'h0;
    rst_i = 1'b1;
    #3;
    check("rst_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    check("rst_mtime", mtime_o, 64'd0);
    check("rst_irq", {63'd0, irq_o}, 64'd0);
    check("rst_dat", {32'd0, bus.wb_dat_o}, 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(1);

    // Register map, byte lanes, reserved words and CTRL field decoding with the timer stopped.
    for (int i = 0; i < NVEC; i++) begin
      xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd, ia, ma);
      check($sformatf("vec%0d", i), {32'd0, rd}, {32'd0, tbl[i].exp_rd});
    end
    check("irq_idle", {63'd0, irq_o}, 64'd0);

    // Held strobe: acks alternate 1,0,1,0.
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 3'd4;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("b2b_ack%0d", i), {63'd0, bus.wb_ack_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    step(1);

    // Cycle without strobe: no ack, no write.
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 3'd2;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check($sformatf("abort_ack%0d", i), {63'd0, bus.wb_ack_o}, 64'd0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus_rd(3'd2, rd);
    check("abort_nowrite", {32'd0, rd}, 64'hFFFF_FFFF);

    // Prescaler DIV=3: first tick 4 edges after enable.
    bus_wr(3'd4, 32'h0000_0301);
    step(40);
    check("presc_40cyc", mtime_o, 64'd10);
    old_mt = mtime_o;
    step(4);
    check("presc_period", mtime_o, old_mt + 64'd1);
    bus_wr(3'd4, 32'h0);
    check("presc_stop", mtime_o, 64'd11);
    step(20);
    check("presc_frozen", mtime_o, 64'd11);

    // Low-to-high carry with DIV=0.
    bus_wr(3'd0, 32'hFFFF_FFFE);
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd4, 32'h1);
    check("carry_tick1", mtime_o, 64'h0000_0000_FFFF_FFFF);
    step(1);
    check("carry_tick2", mtime_o, 64'h0000_0001_0000_0000);
    bus_wr(3'd4, 32'h0);
    check("carry_stop", mtime_o, 64'h0000_0001_0000_0001);

    // Full 64-bit wrap.
    bus_wr(3'd0, 32'hFFFF_FFFF);
    bus_wr(3'd1, 32'hFFFF_FFFF);
    bus_wr(3'd4, 32'h1);
    check("wrap_zero", mtime_o, 64'd0);
    step(1);
    check("wrap_one", mtime_o, 64'd1);
    bus_wr(3'd4, 32'h0);

    // Compare interrupt at mtimecmp = 20.
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd2, 32'd20);
    bus_wr(3'd3, 32'h0);
    check("irq_below", {63'd0, irq_o}, 64'd0);
    bus_wr(3'd4, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mtime_o == 64'd20) found = 1'b1;
      else step(1);
    end
    check("irq_reach20", {63'd0, found}, 64'd1);
    check("irq_not_early", {63'd0, irq_o}, 64'd0);
    step(1);
    check("irq_rise", {63'd0, irq_o}, 64'd1);
    step(5);
    check("irq_level", {63'd0, irq_o}, 64'd1);
    xfer(1'b1, 3'd3, 32'h1, 4'hF, rd, ia, ma);
    check("irq_hold_1edge", {63'd0, ia}, 64'd1);
    check("irq_fall_2edge", {63'd0, irq_o}, 64'd0);

    // Byte-1 write to mtime low word on a tick edge: merge wins, no increment.
    old_mt = mtime_o;
    exp_mt = {old_mt[63:16], 8'hAB, old_mt[7:0]};
    xfer(1'b1, 3'd0, 32'h0000_AB00, 4'h2, rd, ia, ma);
    check("race_prewrite_rd", {32'd0, rd}, {32'd0, old_mt[31:0]});
    check("race_merge", ma, exp_mt);
    check("race_next_tick", mtime_o, exp_mt + 64'd1);

    // Reset in the middle of a pending write.
    bus_wr(3'd3, 32'h0);
    check("pre_rst_irq", {63'd0, irq_o}, 64'd1);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 3'd0;
    bus.wb_dat_i = 32'h0000_5555;
    bus.wb_sel_i = 4'hF;
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    check("arst_irq", {63'd0, irq_o}, 64'd0);
    check("arst_mtime", mtime_o, 64'd0);
    @(posedge clk_i);
    #1;
    check("arst_no_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    rst_i = 1'b0;
    step(1);
    bus_rd(3'd0, rd);
    check("arst_no_commit", {32'd0, rd}, 64'd0);
    bus_rd(3'd2, rd);
    check("arst_cmp_lo", {32'd0, rd}, 64'hFFFF_FFFF);
    bus_rd(3'd4, rd);
    check("arst_ctrl", {32'd0, rd}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
